// File: rtl/uart_pkg.sv
// Shared UART definitions: payload width and the transmit-buffer drain states.
package uart_pkg;

  // Default data bits per frame, shared by transmitter, receiver and buffer.
  localparam int UART_PAYLOAD_BITS = 8;

  // Drain FSM states; 2'b11 is unused and falls back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_ACK  = 2'b01,
    ST_WAIT_DONE = 2'b10
  } drain_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x PAYLOAD_BITS register array: one synchronous write port and an
// asynchronous read port.
module uart_fifo_mem #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [PAYLOAD_BITS-1:0]  wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [PAYLOAD_BITS-1:0]  rdata
);

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];

  // Write the incoming byte into the addressed entry.
  // NOTE: storage has no reset; an entry is only read after it has been written,
  // so clearing it would add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the UART transmitter: a valid/ready byte FIFO
// drained one byte at a time through the uart_tx_en / uart_tx_busy handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = UART_PAYLOAD_BITS,
  parameter int DEPTH        = 16,
  parameter int ACK_TIMEOUT  = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_BITS-1:0]  in_data,
  input  logic                     flush,
  output logic                     uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]  uart_tx_data,
  input  logic                     uart_tx_busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PAYLOAD_BITS-1:0] rd_data;
  logic [CNT_W-1:0]        ack_cnt;
  drain_state_e            state;
  logic                    push;
  logic                    pop;

  // Flags come from the registered level only, so in_ready never depends on
  // a pop happening in the same cycle.
  assign empty    = (level == '0);
  assign full     = (level == LVL_W'(DEPTH));
  assign in_ready = !full;

  // A flush cycle drops both the incoming byte and any hand-off to the transmitter.
  assign push = in_valid && in_ready && !flush;
  assign pop  = (state == ST_IDLE) && !empty && !uart_tx_busy && !flush;

  uart_fifo_mem #(
    .PAYLOAD_BITS (PAYLOAD_BITS),
    .DEPTH        (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Pointer and occupancy bookkeeping; pointers wrap naturally as DEPTH is a power of two.
  // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
    end
  end

  // Drain FSM: hand one byte to the transmitter, wait for busy to rise (or give
  // up after ACK_TIMEOUT cycles), then wait for busy to fall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      ack_cnt      <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
    end else begin
      uart_tx_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            uart_tx_data <= rd_data;
            uart_tx_en   <= 1'b1;
            state        <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // Busy cannot yet reflect this byte while the pulse is still on the wire.
          if (uart_tx_busy && !uart_tx_en) begin
            state   <= ST_WAIT_DONE;
            ack_cnt <= '0;
          end else if (ack_cnt + CNT_W'(1) == CNT_W'(ACK_TIMEOUT)) begin
            state   <= ST_IDLE;
            ack_cnt <= '0;
          end else begin
            ack_cnt <= ack_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!uart_tx_busy) state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          ack_cnt <= '0;
        end
      endcase
    end
  end

endmodule
